// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-side memory for the pipelined MIPS core.
// Word-addressed data RAM plus an MMIO window: output stream FIFO,
// status register, free-running cycle counter and a sticky halt latch.
module dmem_mmio_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halt
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  // Byte-lane bits are ignored: every access is a full word.
  logic [1:0] unusedAddrBits;
  assign unusedAddrBits = aluout[1:0];

  // Address decode
  logic          inRam;
  logic [AW-1:0] ramIdx;
  logic          isMmio;
  logic          isOutData;
  logic          isStatus;
  logic          isCycle;
  logic          isHalt;

  assign inRam     = (aluout[31:AW+2] == '0);
  assign ramIdx    = aluout[AW+1:2];
  assign isMmio    = (aluout[31:4] == 28'hFFFF000);
  assign isOutData = isMmio && (aluout[3:2] == 2'd0);
  assign isStatus  = isMmio && (aluout[3:2] == 2'd1);
  assign isCycle   = isMmio && (aluout[3:2] == 2'd2);
  assign isHalt    = isMmio && (aluout[3:2] == 2'd3);

  // Storage and registered state
  logic [31:0] ramMem  [DEPTH_WORDS];
  logic [31:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0] headReg;
  logic [PW-1:0] tailReg;
  logic [PW:0]   countReg;
  logic          overflowReg;
  logic          haltReg;
  logic [31:0]   cycleReg;

  logic fifoEmpty;
  logic fifoFull;
  logic pushReq;
  logic popReq;
  logic pushOk;
  logic dropPush;

  assign fifoEmpty = (countReg == '0);
  assign fifoFull  = (countReg == FULL_COUNT);
  assign pushReq   = memwrite && isOutData;
  assign popReq    = out_valid && out_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign pushOk    = pushReq && (!fifoFull || popReq);
  assign dropPush  = pushReq && fifoFull && !popReq;

  assign out_valid = !fifoEmpty;
  assign out_data  = fifoMem[headReg];
  assign halt      = haltReg;

  // Data RAM store; deliberately not gated by reset so a store in the reset cycle lands.
  always_ff @(posedge clk) begin
    if (memwrite && inRam) begin
      ramMem[ramIdx] <= writedata;
    end
  end

  // FIFO storage: cleared on reset so out_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem[i] <= '0;
      end
    end else if (pushOk) begin
      fifoMem[tailReg] <= writedata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      headReg  <= '0;
      tailReg  <= '0;
      countReg <= '0;
    end else begin
      if (pushOk) begin
        tailReg <= tailReg + PW'(1);
      end
      if (popReq) begin
        headReg <= headReg + PW'(1);
      end
      case ({pushOk, popReq})
        2'b10:   countReg <= countReg + (PW+1)'(1);
        2'b01:   countReg <= countReg - (PW+1)'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  // Sticky overflow, halt latch and cycle counter (frozen once halted).
  always_ff @(posedge clk) begin
    if (reset) begin
      overflowReg <= 1'b0;
      haltReg     <= 1'b0;
      cycleReg    <= '0;
    end else begin
      if (dropPush) begin
        overflowReg <= 1'b1;
      end else if (memwrite && isStatus && writedata[2]) begin
        overflowReg <= 1'b0;
      end
      if (memwrite && isHalt) begin
        haltReg <= 1'b1;
      end
      if (!haltReg) begin
        cycleReg <= cycleReg + 32'd1;
      end
    end
  end

  // Combinational load mux; reads never change state.
  always_comb begin
    readdata = '0;
    if (inRam) begin
      readdata = ramMem[ramIdx];
    end else if (isStatus) begin
      readdata = {29'b0, overflowReg, fifoFull, fifoEmpty};
    end else if (isCycle) begin
      readdata = cycleReg;
    end else if (isHalt) begin
      readdata = {31'b0, haltReg};
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a vector table for RAM and
// stream behaviour, plus hand-written counter/halt and mid-stream reset runs.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_OUT    = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] A_HALT   = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        halt;

  int nVec = 0;
  int nMiss = 0;
  int cycIdx = 0;

  dmem_mmio_responder #(.DEPTH_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expValid;
    logic [31:0] expData;
    logic        expHalt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string n, logic w, logic [31:0] a, logic [31:0] d, logic r,
                               logic cr, logic [31:0] er, logic ev, logic [31:0] ed, logic eh);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.wd = d; v.rdy = r;
    v.chkRd = cr; v.expRd = er; v.expValid = ev; v.expData = ed; v.expHalt = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    memwrite = w; aluout = a; writedata = d; out_ready = r;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycIdx++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    cycIdx = 0;
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0; out_ready = 1'b0;

    //        name          we  addr       wd          rdy chkRd expRd       vld data        halt
    vecs.push_back(mkv("rst_status",  0, A_STATUS,    0,           0, 1, 32'h1,        0, 32'h0,  0));
    vecs.push_back(mkv("ram_pre",     1, 32'h10,      32'h11111111,0, 0, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("ram_same",    1, 32'h10,      32'hDEADBEEF,0, 1, 32'h11111111, 0, 32'h0,  0));
    vecs.push_back(mkv("ram_rd",      0, 32'h10,      0,           0, 1, 32'hDEADBEEF, 0, 32'h0,  0));
    vecs.push_back(mkv("ram_alias",   0, 32'h13,      0,           0, 1, 32'hDEADBEEF, 0, 32'h0,  0));
    vecs.push_back(mkv("ram_w0",      1, 32'h0,       32'hA5A5A5A5,0, 0, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("ram_oob_w",   1, 32'h100,     32'h12345678,0, 1, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("ram_oob_r",   0, 32'h100,     0,           0, 1, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("ram_idx0",    0, 32'h0,       0,           0, 1, 32'hA5A5A5A5, 0, 32'h0,  0));
    vecs.push_back(mkv("unmap_w",     1, 32'hFFFF0010,32'h5,       0, 1, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("unmap_r",     0, 32'h80000000,0,           0, 1, 32'h0,        0, 32'h0,  0));
    // In-order stream
    vecs.push_back(mkv("push1",       1, A_OUT,       32'h1,       0, 1, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("push2",       1, A_OUT,       32'h2,       0, 1, 32'h0,        1, 32'h1,  0));
    vecs.push_back(mkv("push3",       1, A_OUT,       32'h3,       0, 1, 32'h0,        1, 32'h1,  0));
    vecs.push_back(mkv("st_nempty",   0, A_STATUS,    0,           0, 1, 32'h0,        1, 32'h1,  0));
    vecs.push_back(mkv("pop1",        0, A_STATUS,    0,           1, 1, 32'h0,        1, 32'h1,  0));
    vecs.push_back(mkv("pop2",        0, A_STATUS,    0,           1, 1, 32'h0,        1, 32'h2,  0));
    vecs.push_back(mkv("pop3",        0, A_STATUS,    0,           1, 1, 32'h0,        1, 32'h3,  0));
    vecs.push_back(mkv("drained",     0, A_STATUS,    0,           1, 1, 32'h1,        0, 32'h0,  0));
    // Overflow: five pushes into a four-entry FIFO, head slot is 3
    vecs.push_back(mkv("ovf_p1",      1, A_OUT,       32'h11,      0, 1, 32'h0,        0, 32'h0,  0));
    vecs.push_back(mkv("ovf_p2",      1, A_OUT,       32'h12,      0, 1, 32'h0,        1, 32'h11, 0));
    vecs.push_back(mkv("ovf_p3",      1, A_OUT,       32'h13,      0, 1, 32'h0,        1, 32'h11, 0));
    vecs.push_back(mkv("ovf_p4",      1, A_OUT,       32'h14,      0, 1, 32'h0,        1, 32'h11, 0));
    vecs.push_back(mkv("ovf_p5",      1, A_OUT,       32'h15,      0, 1, 32'h0,        1, 32'h11, 0));
    vecs.push_back(mkv("st_ovf",      0, A_STATUS,    0,           0, 1, 32'h6,        1, 32'h11, 0));
    vecs.push_back(mkv("ovf_clr",     1, A_STATUS,    32'h4,       0, 1, 32'h6,        1, 32'h11, 0));
    vecs.push_back(mkv("st_cleared",  0, A_STATUS,    0,           0, 1, 32'h2,        1, 32'h11, 0));
    // Full push+pop in the same cycle
    vecs.push_back(mkv("full_pp",     1, A_OUT,       32'hAA,      1, 1, 32'h0,        1, 32'h11, 0));
    vecs.push_back(mkv("st_still4",   0, A_STATUS,    0,           1, 1, 32'h2,        1, 32'h12, 0));
    vecs.push_back(mkv("drain13",     0, A_STATUS,    0,           1, 1, 32'h0,        1, 32'h13, 0));
    vecs.push_back(mkv("drain14",     0, A_STATUS,    0,           1, 1, 32'h0,        1, 32'h14, 0));
    vecs.push_back(mkv("drainAA",     0, A_STATUS,    0,           1, 1, 32'h0,        1, 32'hAA, 0));
    vecs.push_back(mkv("drain_end",   0, A_STATUS,    0,           0, 1, 32'h1,        0, 32'h12, 0));

    doReset();
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
      if (vecs[i].chkRd) chk({vecs[i].name, ".rd"}, readdata, vecs[i].expRd);
      chk({vecs[i].name, ".valid"}, 32'(out_valid), 32'(vecs[i].expValid));
      chk({vecs[i].name, ".data"}, out_data, vecs[i].expData);
      chk({vecs[i].name, ".halt"}, 32'(halt), 32'(vecs[i].expHalt));
      tick();
    end

    // Counter and halt
    doReset();
    while (cycIdx < 10) begin drive(1'b0, 32'h0, 32'h0, 1'b0); tick(); end
    drive(1'b0, A_CYCLE, 32'h0, 1'b0);
    chk("cycle_at10", readdata, 32'd10);
    tick();
    while (cycIdx < 20) begin drive(1'b0, 32'h0, 32'h0, 1'b0); tick(); end
    drive(1'b1, A_HALT, 32'h0, 1'b0);
    chk("halt_before", 32'(halt), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, A_CYCLE, 32'h0, 1'b0);
      chk("cycle_frozen", readdata, 32'd21);
      chk("halt_set", 32'(halt), 32'd1);
      tick();
    end
    drive(1'b0, A_HALT, 32'h0, 1'b0);
    chk("halt_rd", readdata, 32'd1);
    tick();
    drive(1'b1, 32'h40, 32'hBEEF0001, 1'b0);
    tick();
    drive(1'b0, 32'h40, 32'h0, 1'b0);
    chk("store_halted", readdata, 32'hBEEF0001);
    tick();

    // Reset mid-stream with a store in the reset cycle
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, A_OUT, 32'h100 + 32'(k), 1'b0);
      tick();
    end
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    chk("ms_queued", 32'(out_valid), 32'd1);
    reset = 1'b1;
    drive(1'b1, 32'h20, 32'h77, 1'b0);
    tick();
    reset = 1'b0;
    cycIdx = 0;
    drive(1'b0, A_CYCLE, 32'h0, 1'b0);
    chk("ms_cycle", readdata, 32'd0);
    chk("ms_valid", 32'(out_valid), 32'd0);
    chk("ms_data", out_data, 32'h0);
    chk("ms_halt", 32'(halt), 32'd0);
    tick();
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    chk("ms_status", readdata, 32'h1);
    tick();
    drive(1'b0, 32'h10, 32'h0, 1'b0);
    chk("ms_ram_keep", readdata, 32'hDEADBEEF);
    tick();
    drive(1'b0, 32'h20, 32'h0, 1'b0);
    chk("ms_ram_rststore", readdata, 32'h77);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Data-side memory responder for the pipelined MIPS core: it receives the memory-stage store/address bus (memwrite, aluout, writedata) and returns load data. It holds a word-addressed data RAM plus a small MMIO window containing a buffered output stream (FIFO with valid/ready drain), a status register, a cycle counter and a halt latch. It sits outside the core at the top level, next to the instruction memory.

## Interface
Parameters:
- DEPTH_WORDS, 64, data RAM size in 32-bit words (power of two, ≥4)
- FIFO_DEPTH, 4, output stream FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- memwrite  in  1  store strobe from memory stage
- aluout  in  32  byte address from memory stage
- writedata  in  32  store data
- readdata  out  32  load data, combinational from aluout
- out_valid  out  1  output stream head valid
- out_data  out  32  output stream head word
- out_ready  in  1  downstream accepts head when high with out_valid
- halt  out  1  sticky halt flag

One clock; reset is synchronous and active-high.

## Operation
- Address bits [1:0] ignored everywhere (word access only).
- Map:
  - RAM: aluout < 4*DEPTH_WORDS; index aluout[log2(DEPTH_WORDS)+1:2].
  - 0xFFFF_0000 OUT_DATA: write pushes writedata into FIFO; read returns 0.
  - 0xFFFF_0004 STATUS: read {29'b0, overflow, full, empty}; write with writedata[2]=1 clears overflow.
  - 0xFFFF_0008 CYCLE: read returns cycle counter; writes ignored.
  - 0xFFFF_000C HALT: any write sets halt; read returns {31'b0, halt}.
  - Any other address: writes ignored, reads return 0.
- Reads have no side effects.
- FIFO:
  - Push on an OUT_DATA write. Pop when out_valid && out_ready.
  - Push while full with no pop in the same cycle: word dropped, overflow set (sticky).
  - Push and pop in the same cycle, including when full: both occur, count unchanged, no overflow.
  - The overflow-clear write and a dropping push can occur in the same cycle only if they are different transactions, which cannot happen (one write per cycle).
  - out_data = head entry. FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH.
- Cycle counter:
  - Increments by 1 every cycle while halt=0, wraps 0xFFFF_FFFF→0.
  - Frozen once halt=1.
- Halt: once set, cleared only by reset. Stores and FIFO drain continue normally while halted.

## Timing
- Reset values (after the reset edge):
  - out_valid=0, out_data=0 (FIFO storage cleared), halt=0, counter=0, overflow=0, FIFO empty.
  - RAM contents are not reset.
- readdata is combinational, same cycle as aluout.
- A store is committed at the rising edge of its cycle; a same-cycle read of the same address returns old data.
- Push latency:
  - An OUT_DATA write in cycle N makes the word visible at out_valid/out_data in cycle N+1 if it is at the head. No empty-FIFO bypass.
- Pop: the head advances at the edge where out_valid && out_ready. out_valid deasserts the cycle after the last entry is popped.
- STATUS reflects registered state; a push in cycle N shows in STATUS from N+1.
- The counter reads value k in the k-th cycle after reset release (first cycle reads 0).
- A HALT write in cycle N:
  - halt=1 from N+1.
  - The counter's last increment is at the edge ending cycle N.
- Reset asserted mid-operation: FIFO is flushed, in-flight stream words are lost, and all registers return to reset values at that edge. A store in the reset cycle is still written to RAM.

## Test plan
- RAM: store 0xDEAD_BEEF to 0x0000_0010 → next cycle read 0x10 returns 0xDEAD_BEEF. Same-cycle read returns the prior value. Address 0x13 aliases 0x10. Address 4*DEPTH_WORDS reads 0.
- Stream in order: out_ready=0; write 1,2,3 to 0xFFFF_0000 → STATUS empty=0. Raise out_ready → out_data 1,2,3 on consecutive cycles, then out_valid=0 and STATUS=0x1.
- Overflow: out_ready=0, write 5 words (FIFO_DEPTH=4) → STATUS=0x6 (full, overflow) and 5th word absent from the stream. Write 0x4 to STATUS → overflow=0.
- Full push+pop: FIFO full, out_ready=1, write 0xAA in the same cycle → no overflow, 0xAA emerges last, count stays 4.
- Counter/halt: read CYCLE at cycle 10 after reset → 10. Write HALT at cycle 20 → halt=1 at 21, CYCLE reads 21 forever after.
- Reset mid-stream: 3 words queued, assert reset one cycle → out_valid=0, STATUS=0x1, CYCLE=0, halt=0. RAM data persists.
